// File: rtl/vmul_wb_collector_if.sv
// Signal bundle between the vector multiply unit, the writeback collector and the register file.
// The master side is upstream/register file; the slave side is the collector.
interface vmul_wb_collector_if #(
  parameter int NUMLANES   = 8,
  parameter int WIDTH      = 32,
  parameter int REGIDWIDTH = 8
);
  logic [NUMLANES*WIDTH-1:0] in_result;
  logic [REGIDWIDTH-1:0]     in_dst;
  logic                      in_dst_we;
  logic [NUMLANES-1:0]       in_dst_mask;
  logic                      in_stall;
  logic                      wb_ready;
  logic                      wb_valid;
  logic [REGIDWIDTH-1:0]     wb_dst;
  logic [NUMLANES*WIDTH-1:0] wb_data;
  logic [NUMLANES-1:0]       wb_mask;
  logic                      full;
  logic [REGIDWIDTH-1:0]     query_dst;
  logic                      query_hit;
  logic                      overflow;
  logic [15:0]               wb_count;

  modport master (
    output in_result, in_dst, in_dst_we, in_dst_mask, in_stall, wb_ready, query_dst,
    input  wb_valid, wb_dst, wb_data, wb_mask, full, query_hit, overflow, wb_count
  );

  modport slave (
    input  in_result, in_dst, in_dst_we, in_dst_mask, in_stall, wb_ready, query_dst,
    output wb_valid, wb_dst, wb_data, wb_mask, full, query_hit, overflow, wb_count
  );
endinterface

// File: rtl/vmul_wb_collector.sv
// Writeback FIFO between the vector multiply unit and a register-file write port,
// with a pending-write hazard lookup across all queued entries.
module vmul_wb_collector #(
  parameter int NUMLANES   = 8,
  parameter int WIDTH      = 32,
  parameter int REGIDWIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic               clk,
  input  logic               reset,
  vmul_wb_collector_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = NUMLANES * WIDTH;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   wb_count_q, wb_count_d;

  logic [DW-1:0]         data_mem [DEPTH];
  logic [REGIDWIDTH-1:0] dst_mem  [DEPTH];
  logic [NUMLANES-1:0]   mask_mem [DEPTH];

  logic push_req, push, pop, head_valid;
  logic [DEPTH-1:0] hit_vec;

  always_comb begin
    head_valid = (count_q != '0);
    pop        = head_valid && bus.wb_ready;
    push_req   = bus.in_dst_we && !bus.in_stall && (bus.in_dst_mask != '0);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push       = push_req && (!full_q || pop);
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
    full_d     = (count_d == CW'(DEPTH));
    overflow_d = overflow_q || (push_req && full_q && !pop);
    wb_count_d = pop ? wb_count_q + 16'd1 : wb_count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      wb_count_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      wb_count_q <= wb_count_d;
    end
  end

  // Storage is deliberately unreset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= bus.in_result;
      dst_mem[wr_ptr_q]  <= bus.in_dst;
      mask_mem[wr_ptr_q] <= bus.in_dst_mask;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
      logic [PW-1:0] offset;
      logic          live;
      always_comb begin
        offset      = PW'(gi) - rd_ptr_q;
        live        = ({1'b0, offset} < count_q);
        hit_vec[gi] = live && (dst_mem[gi] == bus.query_dst);
      end
    end
  endgenerate

  always_comb begin
    bus.wb_valid  = head_valid;
    bus.wb_dst    = head_valid ? dst_mem[rd_ptr_q]  : '0;
    bus.wb_data   = head_valid ? data_mem[rd_ptr_q] : '0;
    bus.wb_mask   = head_valid ? mask_mem[rd_ptr_q] : '0;
    bus.full      = full_q;
    bus.overflow  = overflow_q;
    bus.wb_count  = wb_count_q;
    bus.query_hit = |hit_vec;
  end
endmodule
